// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/memory stages, the port arbiter and the unified RAM.
// The slave modport is the arbiter's view; master is the surrounding pipeline and RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    logic              stall;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ack,
        output stall
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ack,
        input  stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access (IDLE/ACCESS/DONE).
// Optional fetch anti-starvation counter compiled in with MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_t            state_q;
    logic              owner_q;     // 0 = fetch, 1 = data
    logic              ram_req_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic              any_req;
    logic              grant_mem;

    assign any_req = bus.if_req | bus.mem_req;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] starve_q, starve_d;
    logic       fetch_starved;

    assign fetch_starved = bus.if_req && (starve_q == 4'(STARVE_LIMIT));
    assign grant_mem     = bus.mem_req && !fetch_starved;

    // Counts data grants that jumped a waiting fetch; any fetch grant resets it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && any_req) begin
            if (!grant_mem)
                starve_d = '0;
            else if (bus.if_req && starve_q != 4'hF)
                starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign grant_mem = bus.mem_req;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q   <= grant_mem;
                        ram_req_q <= 1'b1;
                        if (grant_mem) begin
                            ram_addr_q  <= bus.mem_addr;
                            ram_we_q    <= bus.mem_we;
                            ram_wdata_q <= bus.mem_wdata;
                        end else begin
                            ram_addr_q  <= bus.if_addr;
                            ram_we_q    <= 1'b0;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.ram_ack) begin
                        ram_req_q <= 1'b0;
                        ram_we_q  <= 1'b0;
                        if (!ram_we_q) begin
                            if (owner_q) mem_rdata_q <= bus.ram_rdata;
                            else         if_rdata_q  <= bus.ram_rdata;
                        end
                        if (owner_q) mem_ready_q <= 1'b1;
                        else         if_ready_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                // Requests are deliberately not looked at here: the served one is still high.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.mem_req & ~mem_ready_q);

    a_ram_stable: assert property (@(posedge clock) disable iff (reset)
        (ram_req_q && !bus.ram_ack) |=> (ram_req_q && $stable(ram_addr_q) && $stable(ram_we_q) && $stable(ram_wdata_q)));

    a_one_ready: assert property (@(posedge clock) disable iff (reset)
        !(if_ready_q && mem_ready_q));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic against a reference memory model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference memory image and expected-response queues.
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_last_load = '0;
    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : rom(a);
    endfunction

    // RAM responder: auto mode acks after ram_lat waiting cycles; manual mode drives force_ack.
    logic ram_manual = 1'b0;
    logic force_ack  = 1'b0;
    logic rand_lat   = 1'b0;
    int   ram_lat    = 0;
    int   wait_cnt   = 0;

    initial begin
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
        forever begin
            @(posedge clock); #2;
            if (ram_manual) begin
                bus.ram_ack = force_ack;
                wait_cnt    = 0;
                if (force_ack) bus.ram_rdata = 32'hBAD0_BAD0;
            end else begin
                bus.ram_ack = 1'b0;
                if (bus.ram_req && !reset) begin
                    if (wait_cnt >= ram_lat) begin
                        bus.ram_ack = 1'b1;
                        wait_cnt    = 0;
                        if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_wdata;
                        else bus.ram_rdata = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : rom(bus.ram_addr);
                        if (rand_lat) ram_lat = $urandom_range(0, 3);
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on ready pulses and checks each new RAM grant.
    logic        p_if_req, p_mem_req, p_mem_we, p_ram_req, p_if_ready, p_mem_ready;
    logic [31:0] p_if_addr, p_mem_addr, p_mem_wdata;
    int          fair_cnt, req_len, last_req_len;
    int          grant_cyc, if_ready_cyc, mem_ready_cyc, n_if_rdy, n_mem_rdy;
    int          grant_log[$];
    logic        own;

    initial begin
        {p_if_req, p_mem_req, p_mem_we, p_ram_req, p_if_ready, p_mem_ready} = '0;
        p_if_addr = '0; p_mem_addr = '0; p_mem_wdata = '0;
        fair_cnt = 0; req_len = 0; last_req_len = 0;
        grant_cyc = 0; if_ready_cyc = 0; mem_ready_cyc = 0; n_if_rdy = 0; n_mem_rdy = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                {p_if_req, p_mem_req, p_ram_req, p_if_ready, p_mem_ready} = '0;
                fair_cnt = 0;
                req_len  = 0;
                continue;
            end
            chk("stall", bus.stall, (bus.if_req & ~bus.if_ready) | (bus.mem_req & ~bus.mem_ready));
            if (bus.if_ready) begin
                n_if_rdy++; if_ready_cyc = cyc;
                chk("if_ready_pulse", p_if_ready, 0);
                if (if_q.size() == 0) chk("if_ready_unexpected", bus.if_ready, 0);
                else chk("if_rdata", bus.if_rdata, if_q.pop_front());
            end
            if (bus.mem_ready) begin
                n_mem_rdy++; mem_ready_cyc = cyc;
                chk("mem_ready_pulse", p_mem_ready, 0);
                if (mem_q.size() == 0) chk("mem_ready_unexpected", bus.mem_ready, 0);
                else chk("mem_rdata", bus.mem_rdata, mem_q.pop_front());
            end
            if (bus.ram_req && !p_ram_req) begin
`ifdef MEM_ARB_FAIRNESS_EN
                own = p_mem_req && !(p_if_req && fair_cnt == LIM);
`else
                own = p_mem_req;
`endif
                chk("grant_had_req", p_if_req | p_mem_req, 1);
                chk("ram_addr", bus.ram_addr, own ? p_mem_addr : p_if_addr);
                chk("ram_we", bus.ram_we, own ? p_mem_we : 1'b0);
                if (own && p_mem_we) chk("ram_wdata", bus.ram_wdata, p_mem_wdata);
                if (!own) fair_cnt = 0;
                else if (p_if_req && fair_cnt < 15) fair_cnt++;
                grant_log.push_back(int'(own));
                grant_cyc = cyc;
                req_len   = 0;
            end
            if (bus.ram_req) req_len++;
            else if (p_ram_req) last_req_len = req_len;
            p_if_req = bus.if_req; p_mem_req = bus.mem_req; p_mem_we = bus.mem_we;
            p_if_addr = bus.if_addr; p_mem_addr = bus.mem_addr; p_mem_wdata = bus.mem_wdata;
            p_ram_req = bus.ram_req; p_if_ready = bus.if_ready; p_mem_ready = bus.mem_ready;
        end
    end

    task automatic fetch_txn(input logic [31:0] a);
        int k;
        if_q.push_back(ref_rd(a));
        bus.if_addr = a;
        bus.if_req  = 1'b1;
        k = 0;
        do begin @(negedge clock); k++; end while (!bus.if_ready && k < 300);
        chk("fetch_done", bus.if_ready, 1);
        @(posedge clock); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        int k;
        if (we) ref_mem[a] = d;
        else    ref_last_load = ref_rd(a);
        mem_q.push_back(ref_last_load);
        bus.mem_we    = we;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_req   = 1'b1;
        k = 0;
        do begin @(negedge clock); k++; end while (!bus.mem_ready && k < 300);
        chk("data_done", bus.mem_ready, 1);
        @(posedge clock); #1;
        bus.mem_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int t0, n0;
    logic [31:0] snap_if, snap_mem, snap_addr;
    int exp_order[4];

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
        ram_mem[32'h40] = 32'h2008_0005;
        ref_mem[32'h40] = 32'h2008_0005;
        repeat (2) @(posedge clock); #1;
        chk("rst_ram_req", bus.ram_req, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_mem_rdata", bus.mem_rdata, 0);
        chk("rst_if_ready", bus.if_ready, 0);
        chk("rst_mem_ready", bus.mem_ready, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Fetch read with immediate ack.
        t0 = cyc; n0 = n_mem_rdy;
        fetch_txn(32'h0000_0040);
        chk("fetch_grant_lat", grant_cyc - t0, 1);
        chk("fetch_ready_lat", if_ready_cyc - t0, 2);
        chk("fetch_no_mem_ready", n_mem_rdy, n0);

        // Data write with the ack in the third access cycle.
        ram_lat = 2;
        t0 = cyc;
        data_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("write_req_len", last_req_len, 3);
        chk("write_ready_lat", mem_ready_cyc - t0, 4);
        ram_lat = 0;

        // Simultaneous requests: data first, fetch sampled in the next IDLE.
        t0 = cyc;
        fork
            fetch_txn(32'h0000_0044);
            data_txn(1'b0, 32'h0000_0100, 32'h0);
        join
        chk("tie_mem_ready_lat", mem_ready_cyc - t0, 2);
        chk("tie_fetch_grant_lat", grant_cyc - t0, 4);
        chk("tie_if_ready_lat", if_ready_cyc - t0, 5);

        // Fetch held while data issues back-to-back requests.
        grant_log.delete();
        fork
            fetch_txn(32'h0000_0048);
            for (int i = 0; i < 4; i++) data_txn(1'b0, 32'h1000_0000 + 32'(i * 4), 32'h0);
        join
`ifdef MEM_ARB_FAIRNESS_EN
        exp_order = '{1, 1, 0, 1};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_order_%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, exp_order[i]);

        // Reset in the middle of an access, then a late ack.
        ram_manual = 1'b1; force_ack = 1'b0;
        bus.if_addr = 32'h0000_0080; bus.if_req = 1'b1;
        repeat (2) @(posedge clock);
        #3; reset = 1'b1; bus.if_req = 1'b0;
        #1;
        chk("abort_ram_req", bus.ram_req, 0);
        chk("abort_ram_addr", bus.ram_addr, 0);
        chk("abort_if_rdata", bus.if_rdata, 0);
        chk("abort_mem_rdata", bus.mem_rdata, 0);
        chk("abort_stall", bus.stall, 0);
        ref_last_load = '0;
        @(posedge clock); #1; reset = 1'b0;
        n0 = n_if_rdy + n_mem_rdy;
        @(posedge clock); #1; force_ack = 1'b1;
        @(posedge clock); #1; force_ack = 1'b0;
        repeat (3) @(negedge clock);
        chk("late_ack_no_ready", n_if_rdy + n_mem_rdy, n0);
        chk("late_ack_ram_req", bus.ram_req, 0);
        chk("late_ack_if_rdata", bus.if_rdata, 0);
        @(posedge clock); #1;
        ram_manual = 1'b0;
        fetch_txn(32'h0000_0084);

        // Spurious ack while idle.
        snap_if = bus.if_rdata; snap_mem = bus.mem_rdata; snap_addr = bus.ram_addr;
        n0 = n_if_rdy + n_mem_rdy;
        ram_manual = 1'b1; force_ack = 1'b1;
        repeat (2) @(posedge clock); #1;
        force_ack = 1'b0;
        repeat (2) @(negedge clock);
        chk("spur_ram_req", bus.ram_req, 0);
        chk("spur_if_rdata", bus.if_rdata, snap_if);
        chk("spur_mem_rdata", bus.mem_rdata, snap_mem);
        chk("spur_ram_addr", bus.ram_addr, snap_addr);
        chk("spur_no_ready", n_if_rdy + n_mem_rdy, n0);
        @(posedge clock); #1;
        ram_manual = 1'b0;

        // Random mixed traffic with random RAM latency.
        rand_lat = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                fetch_txn(32'h0000_2000 | (32'($urandom_range(0, 1023)) << 2));
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                data_txn(1'($urandom_range(0, 1)), 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2), $urandom);
            end
        join
        repeat (5) @(posedge clock);
        chk("if_q_drained", if_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port backing memory between the fetch stage (instruction reads) and the memory stage (data reads and writes) of the five-stage MIPS pipeline. Grants one requester at a time and drives the memory-side request/acknowledge handshake, which tolerates variable latency. Returns read data and a one-cycle ready pulse to the granted stage, plus a combined pipeline stall. Sits between the Fetch and Memory stages and the unified RAM.

## Interface

Parameters:
- `ADDR_W`, 32: byte address width on all ports.
- `DATA_W`, 32: data word width.
- `STARVE_LIMIT`, 4: consecutive data grants tolerated while fetch waits. Used only with fairness compiled in. Legal range is 1..15.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `if_req`  in  1: fetch wants a word; held high until `if_ready`.
- `if_addr`  in  ADDR_W: fetch address.
- `if_rdata`  out  DATA_W: fetched word; valid when `if_ready`=1, held afterwards.
- `if_ready`  out  1: one-cycle completion pulse for fetch.
- `mem_req`  in  1: data access request; held high until `mem_ready`.
- `mem_we`  in  1: 1 = write, 0 = read.
- `mem_addr`  in  ADDR_W: data address.
- `mem_wdata`  in  DATA_W: store data.
- `mem_rdata`  out  DATA_W: load data; valid when `mem_ready`=1, held afterwards.
- `mem_ready`  out  1: one-cycle completion pulse for data.
- `ram_req`  out  1: memory request, held until `ram_ack`.
- `ram_we`  out  1: memory write enable.
- `ram_addr`  out  ADDR_W: memory address.
- `ram_wdata`  out  DATA_W: memory write data.
- `ram_rdata`  in  DATA_W: memory read data; valid in the `ram_ack` cycle.
- `ram_ack`  in  1: memory completion; one or more cycles after `ram_req` rises.
- `stall`  out  1: combinational; `(if_req & ~if_ready) | (mem_req & ~mem_ready)`.

## Operation

- States: IDLE, ACCESS, DONE. A 1-bit `owner` register records the granted requester (0 = fetch, 1 = data).
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise choose a winner: data wins by default; fetch wins only if `mem_req`=0.
  - Latch the winner's address, write enable (fetch is always read) and write data into the `ram_*` registers, and set `owner`.
  - Move to ACCESS.
- ACCESS:
  - `ram_req`=1 with stable `ram_*` outputs.
  - On `ram_ack`=1 for a read: capture `ram_rdata` into the owner's rdata register, then move to DONE.
  - On `ram_ack`=1 for a write: `mem_rdata` is unchanged; move to DONE.
- DONE:
  - The owner's ready output is 1 for exactly this cycle.
  - Requests are not sampled here, so the served request, still high during DONE, is never re-granted.
  - Next state is IDLE.
- `ram_ack` outside ACCESS is ignored.
- Requesters must not change the address or data while their request is pending. Values are latched at grant regardless.
- Reset values:
  - state = IDLE.
  - `ram_req`, `ram_we`, `if_ready`, `mem_ready` = 0.
  - `ram_addr`, `ram_wdata`, `if_rdata`, `mem_rdata` = 0.
  - Starvation counter = 0.
- Reset asserted mid-ACCESS abandons the transaction: `ram_req` drops immediately and no ready pulse is issued. A late `ram_ack` after reset is ignored.

## Timing

- Request first seen high in IDLE at cycle t:
  - `ram_req` high from cycle t+1.
  - `ram_ack` seen at cycle a ≥ t+1; ready pulse at cycle a+1.
  - IDLE again at cycle a+2.
- Minimum turnaround is 3 cycles per access (ack in the first ACCESS cycle).
- Both requests pending: the loser's request is sampled in the next IDLE, so its `ram_req` rises 3 cycles after the winner's at minimum.
- `stall` has zero latency and falls in the ready cycle when only one request is pending.

## Configuration

- `MEM_ARB_FAIRNESS_EN` defined:
  - A saturating counter of width 4 increments on every data grant made while `if_req`=1.
  - It clears on every fetch grant.
  - When the counter equals `STARVE_LIMIT` and both requests are high in IDLE, fetch wins.
- `MEM_ARB_FAIRNESS_EN` undefined: no counter is instantiated; data always wins ties (strict priority).

## Test plan

- Fetch read, ack in first ACCESS cycle, `if_addr`=0x0000_0040, `ram_rdata`=0x2008_0005: `ram_req` high one cycle later with `ram_addr`=0x40; `if_ready` pulses with `if_rdata`=0x2008_0005; `mem_ready` stays 0.
- Data write, `mem_addr`=0x100, `mem_wdata`=0xDEAD_BEEF, ack after 3 cycles: `ram_we`=1 and `ram_wdata`=0xDEAD_BEEF held for 3 cycles; `mem_ready` pulses; `mem_rdata` unchanged; `stall` high until the ready cycle.
- Simultaneous `if_req` and `mem_req` read, ack immediate: data is served first (ready at t+2); fetch `ram_req` rises at t+4; `if_ready` at t+5.
- With `MEM_ARB_FAIRNESS_EN` and `STARVE_LIMIT`=2: `mem_req` held continuously with back-to-back data requests while `if_req` is held → grant order data, data, fetch, data. Without the macro → data every time.
- Reset pulsed during ACCESS (ack withheld), then `ram_ack` asserted one cycle after reset releases: all outputs 0, no ready pulse, state IDLE; a new fetch afterwards completes normally.
- Spurious `ram_ack`=1 in IDLE with no requests: no output changes.
